decimal_key_debouncer: RTL and testbench

- Upstream front end for the decimal-to-binary encoder.
- Takes 10 raw, asynchronous, bouncing decimal key lines (key 0..9).
- Synchronises and debounces them, then checks that exactly one key is pressed.
- Presents a clean, held one-hot `Decimal[9:0]` word and a one-cycle `key_valid` strobe for the encoder to consume.

---
 rtl/decimal_kbd_pkg.sv | 19 +
 rtl/sync_2ff.sv | 24 ++
 rtl/decimal_key_debouncer.sv | 112 +++++++++++
 tb/tb_decimal_key_debouncer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/decimal_kbd_pkg.sv
// Shared definitions for the decimal key debouncer.
// Holds FSM state encodings, key count and the one-hot helper.
package decimal_kbd_pkg;

    localparam int NUM_KEYS = 10;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] PRESS_DB   = 2'd1;
    localparam logic [1:0] HELD       = 2'd2;
    localparam logic [1:0] RELEASE_DB = 2'd3;

    // True when exactly one bit of v is set.
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        logic [NUM_KEYS-1:0] m;
        m = v - NUM_KEYS'(1);
        return (v != '0) && ((v & m) == '0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, cleared by reset.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/decimal_key_debouncer.sv
// Synchronises and debounces 10 decimal key lines, checks for a single key
// and presents a held one-hot word with valid/error strobes.
// Ports: clk, rst (sync, active-high), keys (raw async keys),
//        Decimal (held one-hot key), key_valid / key_error (1-cycle pulses),
//        busy (FSM not idle).
module decimal_key_debouncer
    import decimal_kbd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] Decimal,
    output logic                key_valid,
    output logic                key_error,
    output logic                busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [NUM_KEYS-1:0] ks;
    logic [NUM_KEYS-1:0] pat;
    logic [1:0]          state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_inc;

    sync_2ff #(
        .WIDTH(NUM_KEYS)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (keys),
        .q  (ks)
    );

    // Counter saturates rather than wrapping.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pat       <= '0;
            Decimal   <= '0;
            key_valid <= 1'b0;
            key_error <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            key_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (ks != '0) begin
                        pat   <= ks;
                        cnt   <= CNT_ONE;
                        state <= PRESS_DB;
                    end else begin
                        cnt <= '0;
                    end
                end
                PRESS_DB: begin
                    if (ks == '0) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else if (ks != pat) begin
                        // Pattern changed while settling: start over.
                        pat <= ks;
                        cnt <= CNT_ONE;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= HELD;
                        if (is_onehot(pat)) begin
                            Decimal   <= pat;
                            key_valid <= 1'b1;
                        end else begin
                            key_error <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    // Extra keys while held are ignored; only full release counts.
                    if (ks == '0) begin
                        cnt   <= CNT_ONE;
                        state <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (ks != '0) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Directed bench for decimal_key_debouncer with DEBOUNCE_CYCLES=4.
// Drives keys after the falling edge and samples outputs 1 time unit later.
module tb_decimal_key_debouncer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] keys = '0;
    logic [9:0] Decimal;
    logic       key_valid;
    logic       key_error;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vcount = 0;
    int ecount = 0;
    int vcyc = -1;
    int kcyc = 0;
    int v0 = 0;
    int e0 = 0;
    logic both_hi = 1'b0;
    logic consec = 1'b0;
    logic prev = 1'b0;

    decimal_key_debouncer #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .keys     (keys),
        .Decimal  (Decimal),
        .key_valid(key_valid),
        .key_error(key_error),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (key_valid) begin
            vcount++;
            vcyc = cyc;
        end
        if (key_error) ecount++;
        if (key_valid && key_error) both_hi = 1'b1;
        if ((key_valid || key_error) && prev) consec = 1'b1;
        prev = key_valid || key_error;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        rst = 1'b1;
        tick(2);
        check("rst_decimal", 32'(Decimal), 32'h0);
        check("rst_valid", 32'(key_valid), 32'h0);
        check("rst_error", 32'(key_error), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        tick(1);

        // 1: clean press of key 3
        v0 = vcount; e0 = ecount;
        keys = 10'h008;
        kcyc = cyc + 1;
        tick(20);
        check("t1_valid_cnt", 32'(vcount - v0), 32'd1);
        check("t1_latency", 32'(vcyc - kcyc), 32'd5);
        check("t1_decimal", 32'(Decimal), 32'h008);
        check("t1_no_error", 32'(ecount - e0), 32'd0);
        keys = '0;
        tick(10);
        check("t1_idle", 32'(busy), 32'h0);

        // 2: 2-cycle bounces on key 4, then a stable hold
        v0 = vcount;
        for (int i = 0; i < 3; i++) begin
            keys = 10'h010;
            tick(2);
            keys = '0;
            tick(2);
        end
        check("t2_no_bounce", 32'(vcount - v0), 32'd0);
        keys = 10'h010;
        tick(12);
        check("t2_valid_cnt", 32'(vcount - v0), 32'd1);
        check("t2_decimal", 32'(Decimal), 32'h010);
        keys = '0;
        tick(10);

        // 3: two keys together are rejected
        v0 = vcount; e0 = ecount;
        keys = 10'h003;
        tick(10);
        check("t3_error_cnt", 32'(ecount - e0), 32'd1);
        check("t3_no_valid", 32'(vcount - v0), 32'd0);
        check("t3_decimal", 32'(Decimal), 32'h010);
        keys = '0;
        tick(10);

        // 4: release with bounces, then a repeat press
        v0 = vcount;
        keys = 10'h200;
        tick(10);
        check("t4_first", 32'(vcount - v0), 32'd1);
        check("t4_decimal1", 32'(Decimal), 32'h200);
        for (int i = 0; i < 2; i++) begin
            keys = '0;
            tick(2);
            keys = 10'h200;
            tick(2);
        end
        check("t4_bounce", 32'(vcount - v0), 32'd1);
        keys = '0;
        tick(10);
        keys = 10'h200;
        tick(10);
        check("t4_second", 32'(vcount - v0), 32'd2);
        check("t4_decimal2", 32'(Decimal), 32'h200);
        keys = '0;
        tick(10);

        // 5: extra key while held is ignored
        v0 = vcount; e0 = ecount;
        keys = 10'h001;
        tick(10);
        keys = 10'h003;
        tick(10);
        check("t5_one_pulse", 32'(vcount - v0), 32'd1);
        check("t5_no_error", 32'(ecount - e0), 32'd0);
        check("t5_decimal", 32'(Decimal), 32'h001);
        keys = '0;
        tick(6);
        check("t5_busy", 32'(busy), 32'h0);
        tick(4);

        // 6: reset during press debounce
        v0 = vcount;
        keys = 10'h040;
        tick(3);
        check("t6_busy_pre", 32'(busy), 32'h1);
        rst = 1'b1;
        tick(1);
        check("t6_rst_decimal", 32'(Decimal), 32'h0);
        check("t6_rst_busy", 32'(busy), 32'h0);
        check("t6_rst_valid", 32'(key_valid), 32'h0);
        check("t6_rst_error", 32'(key_error), 32'h0);
        rst = 1'b0;
        kcyc = cyc + 1;
        tick(4);
        check("t6_early", 32'(vcount - v0), 32'd0);
        tick(8);
        check("t6_valid_cnt", 32'(vcount - v0), 32'd1);
        check("t6_latency", 32'(vcyc - kcyc), 32'd5);
        check("t6_decimal", 32'(Decimal), 32'h040);
        keys = '0;
        tick(10);

        // Strobe sanity over the whole run
        check("strobe_overlap", 32'(both_hi), 32'h0);
        check("strobe_consec", 32'(consec), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
